lifo_rd_stream: RTL and testbench
=================================

LIFO_RD_STREAM -- requirements
Module: lifo_rd_stream

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, data word width.
REQ-002 SHALL have parameter AWIDTH, default 8, LIFO address width; fill level is AWIDTH+1 bits wide.
REQ-003 SHALL have one clock and one synchronous, active-high reset: clk_i and srst_i.
REQ-004 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-005 srst_i  input  1  synchronous active-high reset.
REQ-006 drain_i  input  1  single-cycle request to drain the LIFO contents.
REQ-007 lifo_rdreq_o  output  1  read request to the LIFO read port.
REQ-008 lifo_q_i  input  DWIDTH  LIFO read data, valid one cycle after an accepted lifo_rdreq_o.
REQ-009 lifo_empty_i  input  1  LIFO empty flag.
REQ-010 lifo_usedw_i  input  AWIDTH+1  LIFO fill level.
REQ-011 data_o  output  DWIDTH  stream data.
REQ-012 valid_o  output  1  stream data valid.
REQ-013 last_o  output  1  marks the final word of a drain; qualified by valid_o.
REQ-014 ready_i  input  1  downstream accepts the word when valid_o and ready_i are both high.
REQ-015 busy_o  output  1  high while the FSM is in DRAIN.
REQ-016 frames_o  output  16  count of completed drains.

Function
REQ-017 SHALL implement FSM states IDLE and DRAIN.
REQ-018 In IDLE, drain_i=1 with lifo_usedw_i!=0 SHALL latch lifo_usedw_i into a remaining-read counter and move to DRAIN on the next edge.
REQ-019 In IDLE, drain_i=1 with lifo_usedw_i==0 SHALL be ignored; the FSM stays in IDLE and frames_o does not change.
REQ-020 drain_i SHALL be ignored while in DRAIN.
REQ-021 The block SHALL hold a 2-entry output buffer and track at most one in-flight read.
REQ-022 lifo_rdreq_o SHALL be high only when all hold: state DRAIN, remaining>0, !lifo_empty_i, and (occupancy + inflight - (valid_o&ready_i)) < 2. This is a combinational path from ready_i, by design.
REQ-023 Each issued read SHALL decrement remaining by 1. The returned lifo_q_i SHALL be written into the buffer on the next edge, tagged last when it is the final read.
REQ-024 valid_o SHALL equal buffer non-empty. data_o and last_o SHALL come from the buffer head, registered.
REQ-025 data_o and last_o SHALL stay stable while valid_o=1 and ready_i=0.
REQ-026 With drain_i sampled at edge 0 and ready_i held at 1:
  - lifo_rdreq_o first high in cycle 1;
  - valid_o first high in cycle 2;
  - one word per cycle thereafter.
REQ-027 Words SHALL be output in read order, which is LIFO order (newest first).
REQ-028 If lifo_empty_i rises before remaining reaches 0, reads SHALL stall and the FSM SHALL stay in DRAIN. Writes into the LIFO during DRAIN are not blocked, and exactly the latched count is read.
REQ-029 The transfer of the word tagged last SHALL return the FSM to IDLE on the same edge and increment frames_o.
REQ-030 frames_o SHALL wrap from 16'hFFFF to 0.

Reset
REQ-031 srst_i=1 SHALL, on the next edge and from any state, force:
  - FSM to IDLE;
  - buffer occupancy, inflight and remaining to 0;
  - valid_o, last_o, busy_o, lifo_rdreq_o to 0;
  - data_o and frames_o to 0.
REQ-032 A read in flight at reset SHALL be discarded, and srst_i SHALL take priority over drain_i.

Configuration
REQ-033 The statistics feature SHALL be controlled by the macro LIFO_RD_STREAM_STAT_EN.
REQ-034 With LIFO_RD_STREAM_STAT_EN defined, frames_o SHALL count completed drains as in REQ-029 and REQ-030.
REQ-035 With LIFO_RD_STREAM_STAT_EN undefined, no counter register SHALL be built and frames_o SHALL be constant 0. All other behaviour is unchanged.

Verification
REQ-036 Fill: push 4 words A,B,C,D (usedw=4), pulse drain_i, ready_i=1 -> D,C,B,A on consecutive cycles from cycle 2; last_o only with A; frames_o=1.
REQ-037 Empty drain: pulse drain_i with usedw=0 -> busy_o stays 0, no lifo_rdreq_o, frames_o unchanged.
REQ-038 Backpressure: 256 words, ready_i random 50% -> all 256 words in LIFO order; data_o stable while stalled; lifo_rdreq_o never issued with occupancy+inflight=2 and no pop.
REQ-039 Reset mid-drain: 10 words, srst_i after 3 transfers -> next cycle valid_o=0, busy_o=0, frames_o=0; a new drain_i then streams the remaining 7 words.
REQ-040 Ignored drain: drain_i pulsed again during DRAIN -> no extra reads; frames_o increments by exactly 1.
REQ-041 Config: build without LIFO_RD_STREAM_STAT_EN, repeat REQ-036 -> identical stream; frames_o=0 throughout.

Source files
------------

// File: rtl/lifo_rd_stream.sv
// lifo_rd_stream: drains a latched word count from a LIFO read port into a ready/valid stream.
// Drain statistics counter enabled by defining LIFO_RD_STREAM_STAT_EN.
module lifo_rd_stream #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              drain_i,
    output logic              lifo_rdreq_o,
    input  logic [DWIDTH-1:0] lifo_q_i,
    input  logic              lifo_empty_i,
    input  logic [AWIDTH:0]   lifo_usedw_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    output logic              last_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic [15:0]       frames_o
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [AWIDTH:0]   rem_q, rem_d;
    logic              infl_q, infl_d, infl_last_q, infl_last_d;
    logic [1:0]        cnt_q, cnt_d, cnt_p;
    logic [DWIDTH-1:0] b0_q, b0_d, b1_q, b1_d;
    logic              l0_q, l0_d, l1_q, l1_d;
    logic              pop, rd;
    logic [2:0]        room;

    always_comb begin
        pop  = (cnt_q != 2'd0) && ready_i;
        room = {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop};
        rd   = (state_q == DRAIN) && (rem_q != '0) && !lifo_empty_i && (room < 3'd2);
        state_d = state_q;
        rem_d   = rem_q;
        if (state_q == IDLE && drain_i && lifo_usedw_i != '0) begin
            state_d = DRAIN;
            rem_d   = lifo_usedw_i;
        end
        if (rd)
            rem_d = rem_q - 1'b1;
        if (pop && l0_q)
            state_d = IDLE;
        infl_d      = rd;
        infl_last_d = rd && (rem_q == (AWIDTH+1)'(1));
        // Pop shifts the tail into the head; the returning word lands in the first free slot.
        cnt_p = cnt_q - {1'b0, pop};
        b0_d  = pop ? b1_q : b0_q;
        l0_d  = pop ? l1_q : l0_q;
        b1_d  = b1_q;
        l1_d  = l1_q;
        if (infl_q) begin
            if (cnt_p == 2'd0) begin
                b0_d = lifo_q_i;
                l0_d = infl_last_q;
            end else begin
                b1_d = lifo_q_i;
                l1_d = infl_last_q;
            end
        end
        cnt_d = cnt_p + {1'b0, infl_q};
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            cnt_q       <= 2'd0;
            b0_q        <= '0;
            b1_q        <= '0;
            l0_q        <= 1'b0;
            l1_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            cnt_q       <= cnt_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            l0_q        <= l0_d;
            l1_q        <= l1_d;
        end
    end

`ifdef LIFO_RD_STREAM_STAT_EN
    logic [15:0] frames_q, frames_d;

    always_comb frames_d = frames_q + {15'd0, pop && l0_q};

    always_ff @(posedge clk_i) begin
        if (srst_i)
            frames_q <= '0;
        else
            frames_q <= frames_d;
    end

    assign frames_o = frames_q;
`else
    assign frames_o = '0;
`endif

    assign lifo_rdreq_o = rd;
    assign data_o       = b0_q;
    assign last_o       = l0_q;
    assign valid_o      = cnt_q != 2'd0;
    assign busy_o       = state_q == DRAIN;
endmodule

// File: tb/tb_lifo_rd_stream.sv
// tb_lifo_rd_stream: scoreboard bench for lifo_rd_stream with a behavioural LIFO model.
// Frame-count expectations follow LIFO_RD_STREAM_STAT_EN.
module tb_lifo_rd_stream;
    localparam int DW = 16;
    localparam int AW = 8;

    logic          clk_i = 1'b0;
    logic          srst_i = 1'b1;
    logic          drain_i = 1'b0;
    logic          ready_i = 1'b1;
    logic          lifo_rdreq_o, lifo_empty_i, valid_o, last_o, busy_o;
    logic [DW-1:0] lifo_q_i, data_o;
    logic [AW:0]   lifo_usedw_i;
    logic [15:0]   frames_o;

    always #5 clk_i = ~clk_i;

    lifo_rd_stream #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk_i(clk_i), .srst_i(srst_i), .drain_i(drain_i),
        .lifo_rdreq_o(lifo_rdreq_o), .lifo_q_i(lifo_q_i),
        .lifo_empty_i(lifo_empty_i), .lifo_usedw_i(lifo_usedw_i),
        .data_o(data_o), .valid_o(valid_o), .last_o(last_o),
        .ready_i(ready_i), .busy_o(busy_o), .frames_o(frames_o)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // LIFO model: a read returns the top word on the edge that accepts it.
    logic [DW-1:0] mem [0:511];
    int            sp = 0;
    int            nreads = 0;
    int            rd_limit = 1 << 30;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;

    always @(posedge clk_i) begin
        if (lifo_rdreq_o && sp > 0) begin
            lifo_q_i <= mem[sp-1];
            sp       <= sp - 1;
            nreads   <= nreads + 1;
        end else if (wr_en) begin
            mem[sp] <= wr_data;
            sp      <= sp + 1;
        end
    end

    assign lifo_empty_i = (sp == 0) || (nreads >= rd_limit);
    assign lifo_usedw_i = (AW+1)'(sp);

    logic rand_rdy = 1'b0;
    always @(posedge clk_i) begin
        #1;
        ready_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic [DW:0] exp_q [$];
    logic [DW:0] prev_out, e;
    logic        prev_stall = 1'b0;
    int          issued = 0;
    int          popped = 0;

    always @(negedge clk_i) begin
        if (srst_i) begin
            issued     = 0;
            popped     = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("hold", {15'd0, last_o, data_o}, {15'd0, prev_out});
            if (lifo_rdreq_o) begin
                check("rd_room", 32'((issued - popped - int'(valid_o && ready_i)) < 2), 1);
                check("rd_nonempty", {31'd0, lifo_empty_i}, 0);
                issued++;
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("word", {15'd0, last_o, data_o}, {15'd0, e});
                end
                popped++;
            end
            prev_stall = valid_o && !ready_i;
            prev_out   = {last_o, data_o};
        end
    end

    int exp_frames = 0;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic drain(input logic sb);
        drain_i = 1'b1;
        if (sb)
            for (int i = sp - 1; i >= 0; i--)
                exp_q.push_back({i == 0, mem[i]});
        tick();
        drain_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 3000) begin
            tick();
            n++;
        end
        check(tag, 32'(n < 3000), 1);
    endtask

    task automatic frame_done();
`ifdef LIFO_RD_STREAM_STAT_EN
        exp_frames++;
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int n0, b, n;
        tick(3);
        check("rst_valid", {31'd0, valid_o}, 0);
        check("rst_busy", {31'd0, busy_o}, 0);
        check("rst_rdreq", {31'd0, lifo_rdreq_o}, 0);
        check("rst_last", {31'd0, last_o}, 0);
        check("rst_data", {16'd0, data_o}, 0);
        check("rst_frames", {16'd0, frames_o}, 0);
        srst_i = 1'b0;
        tick();

        // Fill A,B,C,D and drain with ready held high.
        push(16'hA0A0); push(16'hB1B1); push(16'hC2C2); push(16'hD3D3);
        drain(1'b1);
        check("lat_busy", {31'd0, busy_o}, 1);
        check("lat_rdreq", {31'd0, lifo_rdreq_o}, 1);
        tick();
        check("lat_v0", {31'd0, valid_o}, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("stream_valid", {31'd0, valid_o}, 1);
            tick();
        end
        frame_done();
        wait_done("fill_done");
        check("fill_frames", {16'd0, frames_o}, 32'(exp_frames));

        // Drain with an empty LIFO is ignored.
        drain(1'b1);
        for (int i = 0; i < 3; i++) begin
            check("empty_busy", {31'd0, busy_o}, 0);
            check("empty_rdreq", {31'd0, lifo_rdreq_o}, 0);
            tick();
        end
        check("empty_frames", {16'd0, frames_o}, 32'(exp_frames));

        // Second drain pulse inside DRAIN adds nothing.
        for (int i = 0; i < 5; i++) push(16'h5000 + 16'(i));
        n0 = nreads;
        drain(1'b1);
        tick();
        drain(1'b0);
        frame_done();
        wait_done("ign_done");
        tick(3);
        check("ign_busy", {31'd0, busy_o}, 0);
        check("ign_reads", 32'(nreads - n0), 5);
        check("ign_frames", {16'd0, frames_o}, 32'(exp_frames));

        // 256 words under random backpressure.
        for (int i = 0; i < 256; i++) push(16'($urandom));
        rand_rdy = 1'b1;
        drain(1'b1);
        frame_done();
        wait_done("bp_done");
        rand_rdy = 1'b0;
        tick(2);
        check("bp_frames", {16'd0, frames_o}, 32'(exp_frames));

        // Reset mid-drain after 3 transfers; the LIFO stalls after 3 reads.
        for (int i = 0; i < 10; i++) push(16'h7700 + 16'(i));
        rd_limit = nreads + 3;
        b = popped;
        drain(1'b1);
        n = 0;
        while (popped < b + 3 && n < 100) begin
            tick();
            n++;
        end
        check("rst_wait", 32'(n < 100), 1);
        tick(2);
        check("stall_busy", {31'd0, busy_o}, 1);
        srst_i = 1'b1;
        tick();
        srst_i = 1'b0;
        exp_q.delete();
        exp_frames = 0;
        check("mid_valid", {31'd0, valid_o}, 0);
        check("mid_busy", {31'd0, busy_o}, 0);
        check("mid_rdreq", {31'd0, lifo_rdreq_o}, 0);
        check("mid_frames", {16'd0, frames_o}, 0);
        rd_limit = 1 << 30;
        check("mid_left", 32'(sp), 7);
        drain(1'b1);
        frame_done();
        wait_done("mid_done");
        tick(2);
        check("mid_frames2", {16'd0, frames_o}, 32'(exp_frames));
        check("lifo_empty", 32'(sp), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
